// File: rtl/data_sram_like_bridge_pkg.sv
// Shared definitions for the data-side sram-like bridge and its helpers.
// Holds the FSM state encoding and the bus transfer size codes.
package data_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridgeState_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// Sram-like bus between the bridge (master) and the SoC data bus (slave).
interface data_sram_like_bridge_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/data_sram_like_bridge_wen_to_size.sv
// Maps byte-write enables to a bus size code and the matching byte address.
// Shared with the instruction-side bridge.
module wen_to_size
  import data_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] cpuAddr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] alignedAddr
);

  logic [1:0] offset;
  logic       unusedLowBits;

  // The enables alone decide the low address bits; unmapped patterns go out as aligned words.
  always_comb begin
    size   = SZ_WORD;
    offset = 2'd0;
    case (wen)
      4'b0001: begin size = SZ_BYTE; offset = 2'd0; end
      4'b0010: begin size = SZ_BYTE; offset = 2'd1; end
      4'b0100: begin size = SZ_BYTE; offset = 2'd2; end
      4'b1000: begin size = SZ_BYTE; offset = 2'd3; end
      4'b0011: begin size = SZ_HALF; offset = 2'd0; end
      4'b1100: begin size = SZ_HALF; offset = 2'd2; end
      default: begin size = SZ_WORD; offset = 2'd0; end
    endcase
  end

  assign alignedAddr   = {cpuAddr[ADDR_W-1:2], offset};
  assign unusedLowBits = ^cpuAddr[1:0];

endmodule

// File: rtl/data_sram_like_bridge.sv
// Turns the core's single-cycle SRAM-style data access into one sram-like
// req/addr_ok/data_ok transaction, stalling the pipeline until it completes.
module data_sram_like_bridge
  import data_sram_like_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int READ_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_en,
  input  logic [3:0]              cpu_wen,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic                    cpu_hold,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall,
  data_sram_like_bridge_if.master bus
);

  localparam logic [1:0] RD_SZ = 2'(READ_SIZE);

  bridgeState_e      state, nextState;
  logic              wrReg;
  logic [1:0]        sizeReg;
  logic [ADDR_W-1:0] addrReg;
  logic [31:0]       wdataReg;
  logic [31:0]       rdBuf;
  logic [1:0]        mapSize;
  logic [ADDR_W-1:0] mapAddr;
  logic              isWrite;

  wen_to_size #(.ADDR_W(ADDR_W)) uWenToSize (
    .wen         (cpu_wen),
    .cpuAddr     (cpu_addr),
    .size        (mapSize),
    .alignedAddr (mapAddr)
  );

  assign isWrite = |cpu_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Request fields are frozen at the start so the bus sees them stable until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrReg    <= 1'b0;
      sizeReg  <= 2'd0;
      addrReg  <= '0;
      wdataReg <= 32'd0;
      rdBuf    <= 32'd0;
    end else begin
      if (state == IDLE && cpu_en) begin
        wrReg    <= isWrite;
        sizeReg  <= isWrite ? mapSize : RD_SZ;
        addrReg  <= isWrite ? mapAddr : {cpu_addr[ADDR_W-1:2], 2'b00};
        wdataReg <= cpu_wdata;
      end
      if (state == DATA && bus.data_ok) begin
        rdBuf <= bus.rdata;
      end
    end
  end

  // DONE ignores cpu_en so a finished access is not reissued while another stage freezes the pipe.
  always_comb begin
    nextState = state;
    bus.req   = 1'b0;
    cpu_stall = 1'b0;
    cpu_rdata = rdBuf;
    case (state)
      IDLE: begin
        cpu_stall = cpu_en;
        if (cpu_en) nextState = ADDR;
      end
      ADDR: begin
        bus.req   = 1'b1;
        cpu_stall = 1'b1;
        if (bus.addr_ok) nextState = DATA;
      end
      DATA: begin
        if (bus.data_ok) begin
          cpu_rdata = bus.rdata;
          nextState = cpu_hold ? DONE : IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      DONE: begin
        if (!cpu_hold) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.wr    = wrReg;
  assign bus.size  = sizeReg;
  assign bus.addr  = addrReg;
  assign bus.wdata = wdataReg;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: inputs change on the falling edge,
// outputs are checked 1ns later against hand-computed values.
module tb_data_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hold;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  int compared   = 0;
  int mismatched = 0;
  int handshakes = 0;

  data_sram_like_bridge_if #(.ADDR_W(32)) bus ();

  data_sram_like_bridge #(.ADDR_W(32), .READ_SIZE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_hold  (cpu_hold),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic r, input logic en, input logic [3:0] wen,
                               input logic [31:0] a, input logic [31:0] wd, input logic hold,
                               input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    rst          = r;
    cpu_en       = en;
    cpu_wen      = wen;
    cpu_addr     = a;
    cpu_wdata    = wd;
    cpu_hold     = hold;
    bus.addr_ok  = aok;
    bus.data_ok  = dok;
    bus.rdata    = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  logic [3:0]  wenTab  [8] = '{4'b0100, 4'b1100, 4'b0001, 4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b0101};
  logic [1:0]  sizeTab [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
  logic [31:0] addrTab [8] = '{32'h8000_0012, 32'h8000_0012, 32'h8000_0010, 32'h8000_0011,
                               32'h8000_0013, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010};

  initial begin
    logic [31:0] wd;

    // Reset
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset req",   32'(bus.req),   32'd0);
    checkOutput("reset stall", 32'(cpu_stall), 32'd0);
    checkOutput("reset wr",    32'(bus.wr),    32'd0);
    checkOutput("reset size",  32'(bus.size),  32'd0);
    checkOutput("reset addr",  bus.addr,       32'd0);
    checkOutput("reset wdata", bus.wdata,      32'd0);
    checkOutput("reset rdata", cpu_rdata,      32'd0);

    // Word load, addr_ok immediately, data_ok two cycles after IDLE->ADDR
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h1FC0_0004, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ld idle stall", 32'(cpu_stall), 32'd1);
    checkOutput("ld idle req",   32'(bus.req),   32'd0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h1FC0_0004, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("ld addr req",   32'(bus.req),   32'd1);
    checkOutput("ld addr wr",    32'(bus.wr),    32'd0);
    checkOutput("ld addr size",  32'(bus.size),  32'd2);
    checkOutput("ld addr addr",  bus.addr,       32'h1FC0_0004);
    checkOutput("ld addr stall", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h1FC0_0004, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ld wait req",   32'(bus.req),   32'd0);
    checkOutput("ld wait stall", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h1FC0_0004, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("ld done stall", 32'(cpu_stall), 32'd0);
    checkOutput("ld done rdata", cpu_rdata,      32'hDEAD_BEEF);
    checkOutput("ld done req",   32'(bus.req),   32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ld after stall", 32'(cpu_stall), 32'd0);
    checkOutput("ld after buf",   cpu_rdata,      32'hDEAD_BEEF);

    // Store size/address mapping
    for (int i = 0; i < 8; i++) begin
      wd = 32'h00AB_0000 | 32'(i);
      applyStimulus(1'b0, 1'b1, wenTab[i], 32'h8000_0010, wd, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("st%0d idle stall", i), 32'(cpu_stall), 32'd1);
      applyStimulus(1'b0, 1'b1, wenTab[i], 32'h8000_0010, wd, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("st%0d req", i),   32'(bus.req),  32'd1);
      checkOutput($sformatf("st%0d wr", i),    32'(bus.wr),   32'd1);
      checkOutput($sformatf("st%0d size", i),  32'(bus.size), 32'(sizeTab[i]));
      checkOutput($sformatf("st%0d addr", i),  bus.addr,      addrTab[i]);
      checkOutput($sformatf("st%0d wdata", i), bus.wdata,     wd);
      applyStimulus(1'b0, 1'b1, wenTab[i], 32'h8000_0010, wd, 1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput($sformatf("st%0d done stall", i), 32'(cpu_stall), 32'd0);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    // addr_ok withheld for 5 cycles; changing cpu inputs must not disturb the request
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_123B, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, (k == 5), 1'b0, 32'h0);
      checkOutput($sformatf("wait%0d req", k),   32'(bus.req),   32'd1);
      checkOutput($sformatf("wait%0d addr", k),  bus.addr,       32'h0000_1238);
      checkOutput($sformatf("wait%0d wr", k),    32'(bus.wr),    32'd0);
      checkOutput($sformatf("wait%0d stall", k), 32'(cpu_stall), 32'd1);
      if (bus.req && bus.addr_ok) handshakes++;
    end
    applyStimulus(1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_2222);
    if (bus.req && bus.addr_ok) handshakes++;
    checkOutput("wait rdata", cpu_rdata, 32'h1111_2222);
    checkOutput("wait handshakes", 32'(handshakes), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Completion under cpu_hold: DONE holds the data and does not reissue
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_2000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_2000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    checkOutput("hold cpl stall", 32'(cpu_stall), 32'd0);
    checkOutput("hold cpl rdata", cpu_rdata,      32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_2000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("hold%0d stall", k), 32'(cpu_stall), 32'd0);
      checkOutput($sformatf("hold%0d rdata", k), cpu_rdata,      32'h1234_5678);
      checkOutput($sformatf("hold%0d req", k),   32'(bus.req),   32'd0);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("hold release stall", 32'(cpu_stall), 32'd0);
    checkOutput("hold release rdata", cpu_rdata,      32'h1234_5678);

    // Back-to-back load then store with cpu_en held high
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0300, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b idle stall", 32'(cpu_stall), 32'd1);
    checkOutput("b2b idle req",   32'(bus.req),   32'd0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0300, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("b2b ld req",  32'(bus.req), 32'd1);
    checkOutput("b2b ld addr", bus.addr,     32'h0000_0300);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h0000_0304, 32'h55AA_55AA, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    checkOutput("b2b ld cpl stall", 32'(cpu_stall), 32'd0);
    checkOutput("b2b ld cpl rdata", cpu_rdata,      32'hCAFE_F00D);
    checkOutput("b2b ld cpl req",   32'(bus.req),   32'd0);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h0000_0304, 32'h55AA_55AA, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b st idle req",   32'(bus.req),   32'd0);
    checkOutput("b2b st idle stall", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h0000_0304, 32'h55AA_55AA, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("b2b st req",   32'(bus.req),  32'd1);
    checkOutput("b2b st wr",    32'(bus.wr),   32'd1);
    checkOutput("b2b st size",  32'(bus.size), 32'd2);
    checkOutput("b2b st addr",  bus.addr,      32'h0000_0304);
    checkOutput("b2b st wdata", bus.wdata,     32'h55AA_55AA);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h0000_0304, 32'h55AA_55AA, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("b2b st cpl stall", 32'(cpu_stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("b2b end req",   32'(bus.req),   32'd0);
    checkOutput("b2b end stall", 32'(cpu_stall), 32'd0);

    // Reset while in DATA
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst data stall before", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst data req",   32'(bus.req),   32'd0);
    checkOutput("rst data stall", 32'(cpu_stall), 32'd0);

    // Reset while in ADDR with req high
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0044, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst addr idle stall", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst addr req before", 32'(bus.req), 32'd1);
    checkOutput("rst addr addr before", bus.addr,    32'h0000_0044);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst addr req",   32'(bus.req),   32'd0);
    checkOutput("rst addr stall", 32'(cpu_stall), 32'd0);
    checkOutput("rst addr addr",  bus.addr,       32'd0);

    // Fresh load after reset
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0048, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post rst idle stall", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0048, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("post rst req",  32'(bus.req), 32'd1);
    checkOutput("post rst addr", bus.addr,     32'h0000_0048);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0048, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post rst wait stall", 32'(cpu_stall), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0000_0048, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0BAD_CAFE);
    checkOutput("post rst cpl stall", 32'(cpu_stall), 32'd0);
    checkOutput("post rst cpl rdata", cpu_rdata,      32'h0BAD_CAFE);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post rst end req", 32'(bus.req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
